// File: rtl/store_narrow_buffer.sv
// store_narrow_buffer: narrows MEM-stage store data to byte/half/word/double,
// places it on the correct byte lanes of a doubleword-aligned write, and queues
// it in a small FIFO that drains to data memory over a valid/ready handshake.
//
// Ports:
//   clk, reset          clock, asynchronous active-low reset
//   in_valid/in_ready   store request handshake
//   in_addr/in_data     byte address and register value of the store
//   in_size             00 byte, 01 half, 10 word, 11 double
//   mem_valid/mem_ready write handshake toward data memory
//   mem_addr            doubleword-aligned address of the head entry
//   mem_wdata           lane-placed, zero-filled write data of the head entry
//   mem_byte_en         byte-lane enables of the head entry
//   count               number of occupied entries
//   misaligned          one-cycle pulse after a misaligned request is consumed
module store_narrow_buffer #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [63:0]            in_addr,
    input  logic [63:0]            in_data,
    input  logic [1:0]             in_size,
    output logic                   mem_valid,
    input  logic                   mem_ready,
    output logic [63:0]            mem_addr,
    output logic [63:0]            mem_wdata,
    output logic [7:0]             mem_byte_en,
    output logic [$clog2(DEPTH):0] count,
    output logic                   misaligned
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef struct packed {
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [7:0]  byte_en;
    } entry_t;

    entry_t          entry_q [DEPTH];
    entry_t          entry_d [DEPTH];
    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;
    logic            in_ready_q, in_ready_d;
    logic            mem_valid_q, mem_valid_d;
    logic            misaligned_q, misaligned_d;

    logic [63:0]     size_mask;
    logic [7:0]      base_be;
    logic            misal;
    logic            accept;
    logic            enq;
    logic            deq;
    entry_t          new_entry;

    // Narrowing, lane placement, alignment check and FIFO bookkeeping.
    always_comb begin
        size_mask    = '1;
        base_be      = 8'hFF;
        misal        = 1'b0;
        entry_d      = entry_q;
        head_d       = head_q;
        tail_d       = tail_q;
        count_d      = count_q;

        case (in_size)
            2'b00: begin
                size_mask = 64'h0000_0000_0000_00FF;
                base_be   = 8'h01;
                misal     = 1'b0;
            end
            2'b01: begin
                size_mask = 64'h0000_0000_0000_FFFF;
                base_be   = 8'h03;
                misal     = in_addr[0];
            end
            2'b10: begin
                size_mask = 64'h0000_0000_FFFF_FFFF;
                base_be   = 8'h0F;
                misal     = |in_addr[1:0];
            end
            default: begin
                size_mask = '1;
                base_be   = 8'hFF;
                misal     = |in_addr[2:0];
            end
        endcase

        new_entry.addr    = {in_addr[63:3], 3'b000};
        new_entry.wdata   = (in_data & size_mask) << {in_addr[2:0], 3'b000};
        new_entry.byte_en = base_be << in_addr[2:0];

        // A misaligned request still completes its handshake but is dropped.
        accept = in_valid & in_ready_q;
        enq    = accept & ~misal;
        deq    = mem_valid_q & mem_ready;

        if (enq) begin
            entry_d[tail_q] = new_entry;
            tail_d          = tail_q + PW'(1);
        end
        if (deq) begin
            head_d = head_q + PW'(1);
        end

        case ({enq, deq})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        in_ready_d   = (count_d != CW'(DEPTH));
        mem_valid_d  = (count_d != '0);
        misaligned_d = accept & misal;
    end

    // State registers; reset clears entries so mem_* read 0 out of reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                entry_q[i] <= '0;
            end
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            in_ready_q   <= 1'b1;
            mem_valid_q  <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            entry_q      <= entry_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            in_ready_q   <= in_ready_d;
            mem_valid_q  <= mem_valid_d;
            misaligned_q <= misaligned_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign mem_valid   = mem_valid_q;
    assign count       = count_q;
    assign misaligned  = misaligned_q;
    assign mem_addr    = entry_q[head_q].addr;
    assign mem_wdata   = entry_q[head_q].wdata;
    assign mem_byte_en = entry_q[head_q].byte_en;

endmodule

// File: tb/tb_store_narrow_buffer.sv
// Self-checking bench for store_narrow_buffer: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_store_narrow_buffer;

    localparam int unsigned DEPTH = 4;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_addr;
    logic [63:0] in_data;
    logic [1:0]  in_size;
    logic        mem_valid;
    logic        mem_ready;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_byte_en;
    logic [2:0]  count;
    logic        misaligned;

    store_narrow_buffer #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_addr     (in_addr),
        .in_data     (in_data),
        .in_size     (in_size),
        .mem_valid   (mem_valid),
        .mem_ready   (mem_ready),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_byte_en (mem_byte_en),
        .count       (count),
        .misaligned  (misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] a;
        logic [63:0] d;
        logic [7:0]  be;
    } ent_t;

    ent_t q[$];
    bit   mis_exp;
    int   n_total;
    int   n_bad;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference narrowing from the size/offset rules using plain arithmetic.
    function automatic ent_t model_entry(input logic [63:0] a, input logic [63:0] d,
                                         input logic [1:0] s);
        ent_t e;
        int   nbytes;
        int   off;
        logic [63:0] mask;
        nbytes = 1 << s;
        off    = int'(a[2:0]);
        mask   = (nbytes == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * nbytes)) - 64'd1);
        e.a    = a - 64'(off);
        e.d    = (d & mask) << (8 * off);
        e.be   = 8'((((1 << nbytes) - 1) << off) & 8'hFF);
        return e;
    endfunction

    function automatic bit model_misaligned(input logic [63:0] a, input logic [1:0] s);
        int nbytes;
        nbytes = 1 << s;
        return (a % 64'(nbytes)) != 0;
    endfunction

    task automatic check_outputs();
        check("mem_valid", 64'(mem_valid), 64'(q.size() != 0));
        check("count", 64'(count), 64'(q.size()));
        check("in_ready", 64'(in_ready), 64'(q.size() != DEPTH));
        check("misaligned", 64'(misaligned), 64'(mis_exp));
        if (q.size() != 0) begin
            check("mem_addr", mem_addr, q[0].a);
            check("mem_wdata", mem_wdata, q[0].d);
            check("mem_byte_en", 64'(mem_byte_en), 64'(q[0].be));
        end
    endtask

    // Drive one cycle from just after a falling edge, advance the model at the
    // rising edge, then check at the next falling edge.
    task automatic cycle(input bit v, input logic [63:0] a, input logic [63:0] d,
                         input logic [1:0] s, input bit mr);
        bit   acc;
        bit   deq;
        bit   mis;
        ent_t e;
        in_valid  = v;
        in_addr   = a;
        in_data   = d;
        in_size   = s;
        mem_ready = mr;
        acc = v && (q.size() != DEPTH);
        deq = (q.size() != 0) && mr;
        mis = model_misaligned(a, s);
        e   = model_entry(a, d, s);
        @(posedge clk);
        if (deq) void'(q.pop_front());
        if (acc && !mis) q.push_back(e);
        mis_exp = acc && mis;
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input bit mr);
        cycle(1'b0, 64'd0, 64'd0, 2'b00, mr);
    endtask

    initial begin
        logic [63:0] a;
        logic [63:0] d;
        logic [1:0]  s;
        n_total   = 0;
        n_bad     = 0;
        mis_exp   = 1'b0;
        in_valid  = 1'b0;
        in_addr   = '0;
        in_data   = '0;
        in_size   = '0;
        mem_ready = 1'b0;
        reset     = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_mem_valid", 64'(mem_valid), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_misaligned", 64'(misaligned), 64'd0);
        check("rst_mem_addr", mem_addr, 64'd0);
        check("rst_mem_wdata", mem_wdata, 64'd0);
        check("rst_mem_byte_en", 64'(mem_byte_en), 64'd0);
        reset = 1'b1;
        @(negedge clk);

        // STURB
        cycle(1'b1, 64'h1003, 64'h1122334455667788, 2'b00, 1'b0);
        check("sturb_addr", mem_addr, 64'h1000);
        check("sturb_wdata", mem_wdata, 64'h0000000088000000);
        check("sturb_be", 64'(mem_byte_en), 64'h08);
        check("sturb_count", 64'(count), 64'd1);
        idle(1'b1);

        // STURH
        cycle(1'b1, 64'h2006, 64'hAAAABBBBCCCCDDDD, 2'b01, 1'b0);
        check("sturh_wdata", mem_wdata, 64'hDDDD000000000000);
        check("sturh_be", 64'(mem_byte_en), 64'hC0);
        idle(1'b1);

        // STUR
        cycle(1'b1, 64'h3000, 64'hDEADBEEFCAFEF00D, 2'b11, 1'b0);
        check("stur_wdata", mem_wdata, 64'hDEADBEEFCAFEF00D);
        check("stur_be", 64'(mem_byte_en), 64'hFF);
        idle(1'b1);

        // Fill to DEPTH with memory stalled; a fifth request must be refused.
        for (int i = 0; i < int'(DEPTH); i++) begin
            cycle(1'b1, 64'h5000 + 64'(8 * i), 64'h0101_0101_0000_0000 + 64'(i), 2'b10, 1'b0);
        end
        check("full_count", 64'(count), 64'(DEPTH));
        check("full_in_ready", 64'(in_ready), 64'd0);
        cycle(1'b1, 64'h6000, 64'h77, 2'b11, 1'b0);
        check("full_hold_count", 64'(count), 64'(DEPTH));
        cycle(1'b0, 64'd0, 64'd0, 2'b00, 1'b1);
        check("free_in_ready", 64'(in_ready), 64'd1);
        repeat (DEPTH) idle(1'b1);

        // Misaligned word store
        cycle(1'b1, 64'h4002, 64'h12345678, 2'b10, 1'b1);
        check("mis_pulse", 64'(misaligned), 64'd1);
        check("mis_count", 64'(count), 64'd0);
        check("mis_mem_valid", 64'(mem_valid), 64'd0);
        idle(1'b1);
        check("mis_pulse_end", 64'(misaligned), 64'd0);

        // Steady-state streaming at count 2 across pointer wrap.
        cycle(1'b1, 64'h7000, 64'hA0, 2'b00, 1'b0);
        cycle(1'b1, 64'h7001, 64'hA1, 2'b00, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 64'h7100 + 64'(2 * i), 64'hB000 + 64'(i), 2'b01, 1'b1);
            check("stream_count", 64'(count), 64'd2);
        end
        repeat (3) idle(1'b1);

        // Asynchronous reset with 3 entries pending.
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 64'h8000 + 64'(8 * i), 64'hC0 + 64'(i), 2'b11, 1'b0);
        end
        in_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("arst_mem_valid", 64'(mem_valid), 64'd0);
        check("arst_count", 64'(count), 64'd0);
        check("arst_in_ready", 64'(in_ready), 64'd1);
        q.delete();
        mis_exp = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        cycle(1'b1, 64'h9008, 64'h55AA, 2'b11, 1'b0);
        check("post_rst_count", 64'(count), 64'd1);
        check("post_rst_wdata", mem_wdata, 64'h55AA);
        idle(1'b1);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            s = 2'($urandom_range(0, 3));
            a = {$urandom(), $urandom()};
            if ($urandom_range(0, 3) != 0) a = a & ~(64'(1 << s) - 64'd1);
            d = {$urandom(), $urandom()};
            cycle(1'($urandom_range(0, 1)), a, d, s, ($urandom_range(0, 9) < 6));
        end
        repeat (DEPTH + 1) idle(1'b1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
